// File: rtl/fsm_pkg.sv
// Shared types and constants for the serial stimulus transmitter and the
// sequence-detector benches that reuse its canonical frames.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } tx_state_t;

  localparam int unsigned DEFAULT_WIDTH   = 16;
  localparam int unsigned CAPTURE_LAT_MAX = 3;

  localparam logic [15:0] FRAME_X = 16'h3BC7;
  localparam logic [15:0] FRAME_Y = 16'h3BF8;

endpackage

// File: rtl/sipo_capture.sv
// Serial-in/parallel-out register, MSB-first. The parallel view includes the
// live serial bit so the final sample is usable on the same edge it arrives.
module sipo_capture
  import fsm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-2:0] sr;

  assign q = {sr, din};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= q[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/dual_serial_tx.sv
// Two-wire (x, y) serial frame transmitter with z response capture.
// Shifts word_x/word_y out MSB-first and returns the captured z frame on done.
module dual_serial_tx
  import fsm_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned CAPTURE_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word_x,
  input  logic [WIDTH-1:0] word_y,
  output logic             ready,
  output logic             x,
  output logic             y,
  output logic             bit_valid,
  input  logic             z_in,
  output logic [WIDTH-1:0] z_word,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  tx_state_t        state, state_nxt;
  logic [WIDTH-2:0] sh_x, sh_y;
  logic             x_q, y_q;
  logic [CW-1:0]    bit_cnt;
  logic [1:0]       drain_cnt;
  logic             accept, last_bit, drain_end, cap_en;
  logic [WIDTH-1:0] cap_word;

  assign ready     = (state == IDLE) || (state == DONE);
  assign done      = (state == DONE);
  assign bit_valid = (state == SHIFT);
  assign x         = x_q;
  assign y         = y_q;

  assign accept    = ready && start;
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign drain_end = (drain_cnt == 2'(CAPTURE_LAT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: if (last_bit) state_nxt = (CAPTURE_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (drain_end) state_nxt = DONE;
      DONE:  state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first bit is loaded straight into the output flop on acceptance, so
  // the shifters only hold the remaining WIDTH-1 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_x      <= '0;
      sh_y      <= '0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      bit_cnt   <= '0;
      drain_cnt <= '0;
      z_word    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sh_x    <= word_x[WIDTH-2:0];
        sh_y    <= word_y[WIDTH-2:0];
        x_q     <= word_x[WIDTH-1];
        y_q     <= word_y[WIDTH-1];
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (last_bit) begin
          x_q <= 1'b0;
          y_q <= 1'b0;
        end else begin
          x_q  <= sh_x[WIDTH-2];
          y_q  <= sh_y[WIDTH-2];
          sh_x <= sh_x << 1;
          sh_y <= sh_y << 1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state_nxt == DONE) begin
        z_word <= cap_word;
      end
    end
  end

  generate
    if (CAPTURE_LAT == 0) begin : g_no_lat
      assign cap_en = bit_valid;
    end else begin : g_lat
      logic [CAPTURE_LAT-1:0] vpipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe <= CAPTURE_LAT'({vpipe, bit_valid});
        end
      end
      assign cap_en = vpipe[CAPTURE_LAT-1];
    end
  endgenerate

  sipo_capture #(
    .WIDTH(WIDTH)
  ) u_z_capture (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .shift_en(cap_en),
    .din     (z_in),
    .q       (cap_word)
  );

endmodule

// File: tb/tb_dual_serial_tx.sv
// Scoreboard bench for dual_serial_tx: instance 0 uses CAPTURE_LAT=0 with a
// combinational loopback, instance 1 uses CAPTURE_LAT=1 with a registered one.
module tb_dual_serial_tx;
  import fsm_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    int          t0;
    int          td;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [15:0] wx [2];
  logic [15:0] wy [2];
  logic        ready [2];
  logic        xo [2];
  logic        yo [2];
  logic        bv [2];
  logic        done [2];
  logic [15:0] zw [2];
  logic        zin0, zin1;
  logic        zsel;
  logic        xd = 1'b0;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb [2][$];
  logic [15:0] acc_x [2];
  logic [15:0] acc_y [2];
  int          nb [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) xd <= xo[1];

  assign zin0 = zsel ? yo[0] : xo[0];
  assign zin1 = xd;

  dual_serial_tx #(.WIDTH(W), .CAPTURE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .word_x(wx[0]), .word_y(wy[0]),
    .ready(ready[0]), .x(xo[0]), .y(yo[0]), .bit_valid(bv[0]), .z_in(zin0),
    .z_word(zw[0]), .done(done[0])
  );

  dual_serial_tx #(.WIDTH(W), .CAPTURE_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .word_x(wx[1]), .word_y(wy[1]),
    .ready(ready[1]), .x(xo[1]), .y(yo[1]), .bit_valid(bv[1]), .z_in(zin1),
    .z_word(zw[1]), .done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Collects serial bits and checks each completed frame against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        nb[i]    = 0;
        acc_x[i] = '0;
        acc_y[i] = '0;
      end else begin
        if (bv[i]) begin
          if (nb[i] == 0 && sb[i].size() > 0)
            chk($sformatf("first_bit_cyc%0d", i), cyc, sb[i][0].t0);
          acc_x[i] = {acc_x[i][14:0], xo[i]};
          acc_y[i] = {acc_y[i][14:0], yo[i]};
          nb[i]++;
        end else begin
          chk($sformatf("xy_idle%0d", i), {xo[i], yo[i]}, 2'b00);
        end
        if (done[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("done_unexp%0d", i), done[i], 1'b0);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            chk($sformatf("x_word%0d", i), acc_x[i], e.x);
            chk($sformatf("y_word%0d", i), acc_y[i], e.y);
            chk($sformatf("nbits%0d", i), nb[i], W);
            chk($sformatf("done_cyc%0d", i), cyc, e.td);
            chk($sformatf("z_word%0d", i), zw[i], e.z);
            chk($sformatf("ready_done%0d", i), ready[i], 1'b1);
          end
          nb[i] = 0;
        end
      end
    end
  end

  task automatic launch(input int i, input logic [15:0] vx, input logic [15:0] vy,
                        input logic [15:0] vz);
    int lat;
    lat = (i == 0) ? 0 : 1;
    @(negedge clk);
    chk($sformatf("ready_pre%0d", i), ready[i], 1'b1);
    wx[i] = vx;
    wy[i] = vy;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    sb[i].push_back('{x: vx, y: vy, z: vz, t0: cyc, td: cyc + W + lat});
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!done[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen%0d", i), done[i], 1'b1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    zsel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      wx[i] = '0;
      wy[i] = '0;
    end

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_ready%0d", i), ready[i], 1'b1);
        chk($sformatf("rst_bv%0d", i), bv[i], 1'b0);
        chk($sformatf("rst_done%0d", i), done[i], 1'b0);
        chk($sformatf("rst_zw%0d", i), zw[i], 16'h0000);
      end
    end

    // Loopback with zero capture latency
    launch(0, FRAME_X, FRAME_Y, FRAME_X);
    wait_done(0);
    @(negedge clk);
    chk("zw_hold0", zw[0], FRAME_X);

    // One-cycle capture latency, registered loopback
    launch(1, FRAME_X, FRAME_Y, FRAME_X);
    wait_done(1);
    @(negedge clk);
    chk("zw_hold1", zw[1], FRAME_X);

    // Back-to-back frames with start held high, z_in = y
    zsel = 1'b1;
    @(negedge clk);
    wx[0] = 16'hFFFF;
    wy[0] = 16'h0000;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    sb[0].push_back('{x: 16'hFFFF, y: 16'h0000, z: 16'h0000, t0: t, td: t + W});
    sb[0].push_back('{x: 16'h0001, y: 16'hAAAA, z: 16'hAAAA, t0: t + W + 1, td: t + 2*W + 1});
    wx[0] = 16'h0001;
    wy[0] = 16'hAAAA;
    repeat (W + 1) @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0);
    zsel = 1'b0;

    // Ignored start and word churn mid-frame
    launch(0, FRAME_X, FRAME_Y, FRAME_X);
    repeat (2) @(posedge clk);
    #1 wx[0] = 16'h0000;
    @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0);
    repeat (20) @(negedge clk);
    chk("churn_zw", zw[0], FRAME_X);

    // Reset mid-frame
    launch(0, FRAME_Y, FRAME_X, FRAME_Y);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    sb[0].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready[0], 1'b1);
    chk("abort_x", xo[0], 1'b0);
    chk("abort_y", yo[0], 1'b0);
    chk("abort_bv", bv[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    chk("abort_zw", zw[0], 16'h0000);
    repeat (3) @(negedge clk);
    launch(0, FRAME_X, FRAME_Y, FRAME_X);
    wait_done(0);
    repeat (5) @(negedge clk);

    chk("sb_left0", sb[0].size(), 0);
    chk("sb_left1", sb[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
